wr_ptr_ctrl: RTL and testbench
==============================

// Module: wr_ptr_ctrl
// PURPOSE
// - Write-domain pointer/flag controller for the async FIFO, successor to the fixed-depth write pointer.
// - Synchronises the read-domain gray pointer internally (SYNC_STAGES flops) and keeps binary/gray write pointers.
// - Produces registered full, almost_full, fill level, accept pulse and a sticky overflow flag.
// - Sits between the write client and the dual-port RAM; the read-side controller consumes g_wr_ptr.
// PARAMETERS
// - DEPTH        16  FIFO entries; power of 2, >=4
// - PTR_SIZE     $clog2(DEPTH)  address bits; pointers are PTR_SIZE+1 wide (wrap bit)
// - SYNC_STAGES  2   read-pointer synchroniser flops, legal 2..4
// - AFULL_THRESH DEPTH-2  almost_full asserts when level >= AFULL_THRESH (1..DEPTH)
// PORTS
// - w_clk         in   1           write clock
// - w_reset_n     in   1           synchronous active-low reset, sampled on posedge w_clk
// - wr_en         in   1           write request
// - ovf_clr       in   1           clears sticky overflow
// - g_rd_ptr      in   PTR_SIZE+1  gray read pointer, read clock domain (asynchronous)
// - wr_addr       out  PTR_SIZE    RAM write address = b_wr_ptr[PTR_SIZE-1:0]
// - b_wr_ptr      out  PTR_SIZE+1  binary write pointer
// - g_wr_ptr      out  PTR_SIZE+1  gray write pointer, always gray(b_wr_ptr), to read domain
// - wr_ack        out  1           1-cycle pulse: write accepted on this edge's request
// - full          out  1           FIFO full (registered)
// - almost_full   out  1           level >= AFULL_THRESH (registered)
// - wr_level      out  PTR_SIZE+1  pessimistic fill level 0..DEPTH (registered)
// - overflow      out  1           sticky: a write was attempted while full
// BEHAVIOUR
// - Single clock w_clk; reset synchronous, active-low. While w_reset_n=0 at an edge: all pointers, sync flops,
//   wr_ack, full, almost_full, wr_level, overflow <= 0. Applies mid-operation; no write accepted that cycle.
// - accept = wr_en & ~full. b_next = b_wr_ptr + accept (mod 2^(PTR_SIZE+1)); g_next = b_next ^ (b_next>>1).
// - b_wr_ptr<=b_next and g_wr_ptr<=g_next on the same edge: g_wr_ptr never lags b_wr_ptr, changes 1 bit/write.
// - wr_ack <= accept. RAM writes at wr_addr when accept is high (address valid same cycle as request).
// - Sync: g_rd_ptr shifts through SYNC_STAGES flops; g_rd_s = last stage; b_rd_s = gray-to-binary(g_rd_s).
//   Read progress visible to flags SYNC_STAGES+1 edges after g_rd_ptr changes (pessimistic: flags never lie unsafe).
// - Registered flags from next-state values:
//   full        <= (g_next == {~g_rd_s[PTR_SIZE:PTR_SIZE-1], g_rd_s[PTR_SIZE-2:0]})
//   wr_level    <= b_next - b_rd_s (PTR_SIZE+1 bit modular subtract; result 0..DEPTH)
//   almost_full <= (b_next - b_rd_s) >= AFULL_THRESH
// - full rises on the same edge that accepts the DEPTH-th outstanding write; wr_en while full is ignored
//   (pointers hold, wr_ack=0).
// - Wrap: pointers roll over 2^(PTR_SIZE+1)-1 -> 0; MSB toggles every DEPTH writes; full/level correct across wrap.
// - Simultaneous write + read-pointer advance: both folded into the same next-state compare; no glitch.
// - overflow <= (wr_en & full) | (overflow & ~ovf_clr); set wins over clear in the same cycle.
// - No combinational path from wr_en to full/almost_full/wr_level; wr_addr/b_wr_ptr/g_wr_ptr are flop outputs.
// TESTING (DEPTH=8, SYNC_STAGES=2, AFULL_THRESH=6 unless stated)
// - Reset: hold w_reset_n=0 2 cycles with wr_en=1 -> all outputs 0, b_wr_ptr stays 0; release -> first write at addr 0.
// - Fill: g_rd_ptr=0, wr_en=1 for 10 cycles -> wr_ack for 8 cycles, almost_full after 6th, full after 8th,
//   wr_level=8, b_wr_ptr=8 (4'b1000), g_wr_ptr=4'b1100, overflow=1 from the 9th request.
// - Drain visibility: from full, drive g_rd_ptr=gray(3)=4'b0010 -> full=0, wr_level=5, almost_full=0 exactly
//   3 edges later; no earlier change.
// - Wrap: 20 writes interleaved with read pointer kept 2 behind -> b_wr_ptr 15->0 rollover, full never set,
//   g_wr_ptr Hamming distance 1 per accepted write (checker).
// - Overflow clear: overflow=1, pulse ovf_clr with wr_en=0 -> overflow=0 next edge; ovf_clr=1 with wr_en&full -> stays 1.
// - Mid-operation reset: at wr_level=5 assert w_reset_n=0 one cycle -> next edge b_wr_ptr=0, wr_level=0,
//   full=0, overflow=0; repeat suite with DEPTH=32, SYNC_STAGES=3, AFULL_THRESH=32.

Source files
------------

// File: rtl/wr_ptr_ctrl_if.sv
// Write-side FIFO controller bus: client request/flag signals plus the
// cross-domain gray pointers exchanged with the read-side controller.
interface wr_ptr_ctrl_if #(
  parameter int PTR_SIZE = 4
);
  logic                wr_en;
  logic                ovf_clr;
  logic [PTR_SIZE:0]   g_rd_ptr;
  logic [PTR_SIZE-1:0] wr_addr;
  logic [PTR_SIZE:0]   b_wr_ptr;
  logic [PTR_SIZE:0]   g_wr_ptr;
  logic                wr_ack;
  logic                full;
  logic                almost_full;
  logic [PTR_SIZE:0]   wr_level;
  logic                overflow;

  modport master (
    output wr_en, ovf_clr, g_rd_ptr,
    input  wr_addr, b_wr_ptr, g_wr_ptr, wr_ack, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, ovf_clr, g_rd_ptr,
    output wr_addr, b_wr_ptr, g_wr_ptr, wr_ack, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/wr_ptr_ctrl.sv
// Async FIFO write-domain controller: binary/gray write pointers, read-pointer
// synchroniser and registered full/almost_full/level/overflow flags.
module wr_ptr_ctrl #(
  parameter int DEPTH        = 16,
  parameter int PTR_SIZE     = $clog2(DEPTH),
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic          w_clk,
  input logic          w_reset_n,
  wr_ptr_ctrl_if.slave bus
);
  localparam logic [PTR_SIZE:0] AFULL_LVL = (PTR_SIZE + 1)'(AFULL_THRESH);

  logic [PTR_SIZE:0] sync_q [SYNC_STAGES];
  logic [PTR_SIZE:0] g_rd_s;
  logic [PTR_SIZE:0] b_rd_s;
  logic [PTR_SIZE:0] b_next;
  logic [PTR_SIZE:0] g_next;
  logic [PTR_SIZE:0] level_next;
  logic              accept;

  logic [PTR_SIZE:0] b_q;
  logic [PTR_SIZE:0] g_q;
  logic [PTR_SIZE:0] level_q;
  logic              ack_q;
  logic              full_q;
  logic              afull_q;
  logic              ovf_q;

  assign g_rd_s = sync_q[SYNC_STAGES-1];

  // Gray-to-binary as a prefix XOR of successively shifted copies.
  always_comb begin
    b_rd_s = g_rd_s;
    for (int unsigned i = 1; i <= unsigned'(PTR_SIZE); i++) begin
      b_rd_s = b_rd_s ^ (g_rd_s >> i);
    end
  end

  assign accept     = bus.wr_en & ~full_q;
  assign b_next     = b_q + {{PTR_SIZE{1'b0}}, accept};
  assign g_next     = b_next ^ (b_next >> 1);
  assign level_next = b_next - b_rd_s;

  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      sync_q  <= '{default: '0};
      b_q     <= '0;
      g_q     <= '0;
      level_q <= '0;
      ack_q   <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q[0] <= bus.g_rd_ptr;
      for (int unsigned i = 1; i < unsigned'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      b_q     <= b_next;
      g_q     <= g_next;
      ack_q   <= accept;
      // Full when the next write pointer sits exactly one lap ahead of the
      // synchronised read pointer (top two gray bits inverted).
      full_q  <= (g_next == {~g_rd_s[PTR_SIZE:PTR_SIZE-1], g_rd_s[PTR_SIZE-2:0]});
      level_q <= level_next;
      afull_q <= (level_next >= AFULL_LVL);
      ovf_q   <= (bus.wr_en & full_q) | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.wr_addr     = b_q[PTR_SIZE-1:0];
  assign bus.b_wr_ptr    = b_q;
  assign bus.g_wr_ptr    = g_q;
  assign bus.wr_ack      = ack_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wr_level    = level_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Lockstep bench for two wr_ptr_ctrl configurations (8/2/6 and 32/3/32)
// against a write/read counting model with a delayed read-count history.
module tb_wr_ptr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic ovf_clr = 1'b0;
  int   rd [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wr_ptr_ctrl_if #(.PTR_SIZE(3)) ia ();
  wr_ptr_ctrl_if #(.PTR_SIZE(5)) ib ();

  wr_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut_a (
    .w_clk(clk), .w_reset_n(rst_n), .bus(ia.slave)
  );
  wr_ptr_ctrl #(.DEPTH(32), .SYNC_STAGES(3), .AFULL_THRESH(32)) dut_b (
    .w_clk(clk), .w_reset_n(rst_n), .bus(ib.slave)
  );

  // Reference model: total accepted writes vs. read count seen SYNC_STAGES edges late.
  int DEP [2] = '{8, 32};
  int SS  [2] = '{2, 3};
  int TH  [2] = '{6, 32};
  int m_wr  [2];
  int m_lvl [2];
  bit m_full[2];
  bit m_af  [2];
  bit m_ovf [2];
  bit m_ack [2];
  int ecnt  [2];
  int hist  [2][8];
  int gprev [2];

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_edge(int i);
    int vis;
    bit acc;
    bit old_full;
    old_full = m_full[i];
    if (!rst_n) begin
      m_wr[i] = 0; m_lvl[i] = 0; m_full[i] = 0; m_af[i] = 0; m_ovf[i] = 0; m_ack[i] = 0;
      ecnt[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = 0;
    end else begin
      ecnt[i]++;
      hist[i][ecnt[i] % 8] = rd[i];
      vis = hist[i][(ecnt[i] + 8 - SS[i]) % 8];
      acc = wr_en && !old_full;
      m_wr[i] += acc ? 1 : 0;
      m_lvl[i] = m_wr[i] - vis;
      m_full[i] = (m_lvl[i] == DEP[i]);
      m_af[i] = (m_lvl[i] >= TH[i]);
      m_ovf[i] = (wr_en && old_full) || (m_ovf[i] && !ovf_clr);
      m_ack[i] = acc;
    end
  endtask

  task automatic check(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_inst(int i, logic [31:0] addr, logic [31:0] b, logic [31:0] g,
                            logic [31:0] ack, logic [31:0] full, logic [31:0] af,
                            logic [31:0] lvl, logic [31:0] ovf);
    int bexp;
    bexp = m_wr[i] % (2 * DEP[i]);
    check("wr_addr", i, addr, 32'(m_wr[i] % DEP[i]));
    check("b_wr_ptr", i, b, 32'(bexp));
    check("g_wr_ptr", i, g, 32'(gray(bexp)));
    check("wr_ack", i, ack, 32'(m_ack[i]));
    check("full", i, full, 32'(m_full[i]));
    check("almost_full", i, af, 32'(m_af[i]));
    check("wr_level", i, lvl, 32'(m_lvl[i]));
    check("overflow", i, ovf, 32'(m_ovf[i]));
    if (rst_n) check("gray_step", i, 32'($countones(g ^ 32'(gprev[i]))), m_ack[i] ? 32'd1 : 32'd0);
    gprev[i] = int'(g);
  endtask

  task automatic step();
    ia.wr_en = wr_en;  ia.ovf_clr = ovf_clr;  ia.g_rd_ptr = 4'(gray(rd[0] % 16));
    ib.wr_en = wr_en;  ib.ovf_clr = ovf_clr;  ib.g_rd_ptr = 6'(gray(rd[1] % 64));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_inst(0, 32'(ia.wr_addr), 32'(ia.b_wr_ptr), 32'(ia.g_wr_ptr), 32'(ia.wr_ack),
               32'(ia.full), 32'(ia.almost_full), 32'(ia.wr_level), 32'(ia.overflow));
    check_inst(1, 32'(ib.wr_addr), 32'(ib.b_wr_ptr), 32'(ib.g_wr_ptr), 32'(ib.wr_ack),
               32'(ib.full), 32'(ib.almost_full), 32'(ib.wr_level), 32'(ib.overflow));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) gprev[i] = 0;

    // Reset held with a pending write request.
    rst_n = 1'b0; wr_en = 1'b1;
    repeat (2) step();
    check("rst_b_hold", 0, 32'(ia.b_wr_ptr), 32'd0);

    // Fill: 10 requests, DEPTH=8 instance saturates.
    rst_n = 1'b1;
    repeat (10) step();
    check("fill_level", 0, 32'(ia.wr_level), 32'd8);
    check("fill_b", 0, 32'(ia.b_wr_ptr), 32'b1000);
    check("fill_g", 0, 32'(ia.g_wr_ptr), 32'b1100);
    check("fill_full", 0, 32'(ia.full), 32'd1);
    check("fill_ovf", 0, 32'(ia.overflow), 32'd1);

    // Drain visibility: read count 3 appears on the flags on the third edge.
    wr_en = 1'b0; rd[0] = 3; rd[1] = 3;
    repeat (2) step();
    check("drain_early_full", 0, 32'(ia.full), 32'd1);
    step();
    check("drain_full", 0, 32'(ia.full), 32'd0);
    check("drain_level", 0, 32'(ia.wr_level), 32'd5);
    check("drain_af", 0, 32'(ia.almost_full), 32'd0);

    // Overflow clear, then set-wins-over-clear while full.
    ovf_clr = 1'b1;
    step();
    check("ovf_cleared", 0, 32'(ia.overflow), 32'd0);
    ovf_clr = 1'b0; wr_en = 1'b1;
    repeat (3) step();
    check("refill_full", 0, 32'(ia.full), 32'd1);
    ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", 0, 32'(ia.overflow), 32'd1);
    ovf_clr = 1'b0;

    // Wrap with the reader trailing two entries behind.
    rst_n = 1'b0; rd[0] = 0; rd[1] = 0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 2; i++) rd[i] = (m_wr[i] > 2) ? m_wr[i] - 2 : 0;
      step();
      check("wrap_no_full", 0, 32'(ia.full), 32'd0);
    end
    check("wrap_b", 0, 32'(ia.b_wr_ptr), 32'd4);

    // Mid-operation reset at level 5.
    rst_n = 1'b0; rd[0] = 0; rd[1] = 0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("mid_level5", 0, 32'(ia.wr_level), 32'd5);
    rst_n = 1'b0;
    step();
    check("mid_rst_b", 0, 32'(ia.b_wr_ptr), 32'd0);
    check("mid_rst_level", 0, 32'(ia.wr_level), 32'd0);
    check("mid_rst_full", 0, 32'(ia.full), 32'd0);
    check("mid_rst_ovf", 0, 32'(ia.overflow), 32'd0);
    rst_n = 1'b1;

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      wr_en   = ($urandom % 4) != 0;
      ovf_clr = ($urandom % 8) == 0;
      rst_n   = ($urandom % 97) != 0;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) rd[i] = 0;
        else if (($urandom % 3) == 0 && rd[i] < m_wr[i])
          rd[i] += int'($urandom_range(1, m_wr[i] - rd[i]));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
